rom_arbiter: RTL

//  Shares the single-ported boot ROM between the instruction-fetch port and the data-load port.

---
 rtl/rom_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares the single-ported boot ROM between fetch and load.
// Serialises one-cycle requests and routes each response to its owner.
module rom_arbiter #(
  parameter int ARB_MODE = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        rom_valid,
  output logic        rom_instr,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rdata,
  input  logic        rom_ready,
  output logic        arb_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_pend_i;
  logic        r_pend_d;
  logic        r_last_i;
  logic        r_err;
  logic [31:0] r_addr_i;
  logic [31:0] r_addr_d;

  logic        w_acc_i;
  logic        w_acc_d;
  logic        w_bad;
  logic        w_cand_i;
  logic        w_cand_d;
  logic        w_done_i;
  logic        w_done_d;
  logic        w_issue;
  logic        w_sel_i;
  logic [31:0] w_addr_i;
  logic [31:0] w_addr_d;

  // A valid on a port that still owns an unfinished request is dropped.
  assign w_acc_i  = imem_valid & ~r_pend_i & ~reset;
  assign w_acc_d  = dmem_valid & ~r_pend_d & ~reset;
  assign w_bad    = (imem_valid & r_pend_i)
                  | (dmem_valid & r_pend_d);

  assign w_cand_i = r_pend_i | w_acc_i;
  assign w_cand_d = r_pend_d | w_acc_d;
  assign w_addr_i = w_acc_i ? imem_addr : r_addr_i;
  assign w_addr_d = w_acc_d ? dmem_addr : r_addr_d;

  assign w_done_i = rom_ready & (r_state == BUSY_I);
  assign w_done_d = rom_ready & (r_state == BUSY_D);

  always_comb begin
    w_issue = 1'b0;
    w_sel_i = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_issue = w_cand_i | w_cand_d;
        if (w_cand_i & w_cand_d)
          w_sel_i = (ARB_MODE != 0) & ~r_last_i;
        else
          w_sel_i = w_cand_i;
      end
      BUSY_I: begin
        w_issue = rom_ready & w_cand_d;
        w_sel_i = 1'b0;
      end
      BUSY_D: begin
        w_issue = rom_ready & w_cand_i;
        w_sel_i = 1'b1;
      end
      default: begin
        w_issue = 1'b0;
        w_sel_i = 1'b0;
      end
    endcase
  end

  assign rom_valid  = w_issue;
  assign rom_instr  = w_issue & w_sel_i;
  assign rom_addr   = !w_issue ? '0 :
                      w_sel_i  ? w_addr_i : w_addr_d;

  assign imem_ready = w_done_i;
  assign imem_rdata = w_done_i ? rom_rdata : '0;
  assign dmem_ready = w_done_d;
  assign dmem_rdata = w_done_d ? rom_rdata : '0;
  assign arb_error  = r_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_pend_i <= 1'b0;
      r_pend_d <= 1'b0;
      r_last_i <= 1'b0;
      r_err    <= 1'b0;
      r_addr_i <= '0;
      r_addr_d <= '0;
    end else begin
      if (w_acc_i) begin
        r_pend_i <= 1'b1;
        r_addr_i <= imem_addr;
      end else if (w_done_i) begin
        r_pend_i <= 1'b0;
      end
      if (w_acc_d) begin
        r_pend_d <= 1'b1;
        r_addr_d <= dmem_addr;
      end else if (w_done_d) begin
        r_pend_d <= 1'b0;
      end
      if (w_bad)
        r_err <= 1'b1;
      // A new issue overrides the return to IDLE (back-to-back grant).
      if (w_issue) begin
        r_state  <= w_sel_i ? BUSY_I : BUSY_D;
        r_last_i <= w_sel_i;
      end else if (w_done_i | w_done_d) begin
        r_state <= IDLE;
      end
    end
  end

endmodule
